system_worker_ocm_v2: RTL and testbench

SYSTEM_WORKER_OCM_V2 -- requirements
Module: system_worker_ocm_v2

---
 rtl/system_worker_ocm_pkg.sv | 20 ++
 rtl/system_worker_ocm_ram.sv | 38 +++
 rtl/system_worker_ocm_v2.sv | 129 ++++++++++++
 tb/tb_system_worker_ocm_v2.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_worker_ocm_pkg.sv
// Shared types and parameter legality checks for the on-chip memory worker.
package system_worker_ocm_pkg;

  // Controller states: CLEAR zero-fills the array, READY serves commands.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ocm_state_t;

  // Read latency is either one or two enabled cycles.
  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Word width must be a whole number of bytes between 8 and 128 bits.
  function automatic bit data_w_ok(input int w);
    return (w >= 8) && (w <= 128) && ((w % 8) == 0);
  endfunction

endpackage

// File: rtl/system_worker_ocm_ram.sv
// Single-port RAM with byte enables, registered address and clock enable.
// The read port looks up the registered address in the array, so a word
// written on one edge is visible to a read whose address registers later
// (write-first from the bus's point of view).
module system_worker_ocm_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;

  // Byte-lane writes and address capture, both frozen while ce is low.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      addr_q <= addr;
    end
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/system_worker_ocm_v2.sv
// Avalon-MM on-chip memory worker: optional zero-fill after reset, byte-lane
// writes, pipelined reads with a READ_LAT-deep valid shift register.
//
// Handshake: a command is taken in any cycle where chipselect and (read or
// write) are high and waitrequest is low; the master must hold the command
// while waitrequest is high. Each taken read (without write) returns exactly
// one readdatavalid pulse, in order, READ_LAT enabled cycles later.
module system_worker_ocm_v2
  import system_worker_ocm_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 7,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("READ_LAT must be 1 or 2");
  end
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8 in 8..128");
  end

  localparam ocm_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic                en;
  ocm_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clearing;
  logic                accept, wr_acc, rd_acc;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   pipe_data;
  logic [DATA_W-1:0]   rd_hold;

  assign en       = clken & ~reset_req;
  assign clearing = (state_q == ST_CLEAR);

  // State register; reset wins over the enable.
  always_ff @(posedge clk) begin
    if (reset)   state_q <= RESET_STATE;
    else if (en) state_q <= state_d;
  end

  // Leave CLEAR on the cycle that writes the last word.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_cnt == '1) state_d = ST_READY;
  end

  // Clear pointer walks the array once per enabled CLEAR cycle.
  always_ff @(posedge clk) begin
    if (reset)             clr_cnt <= '0;
    else if (en && clearing) clr_cnt <= clr_cnt + 1'b1;
  end

  assign waitrequest = clearing | ~en;
  assign init_done   = (state_q == ST_READY);

  // A simultaneous read and write is treated as a write only.
  assign accept = chipselect & (read | write) & ~waitrequest;
  assign wr_acc = accept & write;
  assign rd_acc = accept & read & ~write;

  // The clear engine owns the RAM port while clearing; writes never land during reset.
  assign ram_we    = ~reset & (clearing | wr_acc);
  assign ram_addr  = clearing ? clr_cnt : address;
  assign ram_be    = clearing ? '1 : byteenable;
  assign ram_wdata = clearing ? '0 : writedata;

  system_worker_ocm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .ce    (en),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read-valid shift register; flushed by reset, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset)   vld_q <= '0;
    else if (en) vld_q <= (vld_q << 1) | READ_LAT'(rd_acc);
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] stage_q;
    // Extra output stage captures the RAM word one enabled cycle after acceptance.
    always_ff @(posedge clk) begin
      if (en && vld_q[0]) stage_q <= ram_rdata;
    end
    assign pipe_data = stage_q;
  end else begin : g_lat1
    assign pipe_data = ram_rdata;
  end

  assign readdatavalid = vld_q[READ_LAT-1] & en & ~reset;

  // Remember the last returned word so readdata is stable between pulses.
  always_ff @(posedge clk) begin
    if (reset)              rd_hold <= '0;
    else if (readdatavalid) rd_hold <= pipe_data;
  end

  assign readdata = readdatavalid ? pipe_data : rd_hold;

endmodule

// File: tb/tb_system_worker_ocm_v2.sv
// Bench for system_worker_ocm_v2 (DATA_W=32, ADDR_W=7, READ_LAT=2, clear on reset).
module tb_system_worker_ocm_v2;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int RL = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req, chipselect, read, write;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata, readdata;
  logic          readdatavalid, waitrequest, init_done;

  system_worker_ocm_v2 #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .init_done(init_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Memory image, clear progress, and the list of reads owed, each tagged
  // with the enabled-cycle number at which it falls due.
  logic [DW-1:0] m_mem [128];
  bit            m_clearing = 1'b1;
  int            m_clr_idx  = 0;
  int            m_en_cnt   = 0;
  logic [DW-1:0] m_last     = '0;
  logic [DW-1:0] exp_q [$];
  int            due_q [$];

  logic          e_wait, e_done, e_valid;
  logic [DW-1:0] e_data;
  logic          o_wait, o_done, o_valid;
  logic [DW-1:0] o_data;

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
  endtask

  task automatic set_cmd(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] d);
    reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
    chipselect = 1'b1; read = rd; write = wr;
    address = a; byteenable = be; writedata = d;
  endtask

  // One clock: predict this cycle's outputs, sample the DUT at the falling
  // edge, then advance the model across the rising edge.
  task automatic step();
    bit en;
    en      = clken & ~reset_req;
    e_wait  = m_clearing | ~en;
    e_done  = ~m_clearing;
    e_valid = 1'b0;
    e_data  = m_last;
    if (en && !reset && due_q.size() > 0 && due_q[0] == m_en_cnt) begin
      e_valid = 1'b1;
      e_data  = exp_q[0];
    end
    @(negedge clk);
    o_wait = waitrequest; o_done = init_done; o_valid = readdatavalid; o_data = readdata;
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); due_q.delete();
      m_last = '0; m_clearing = 1'b1; m_clr_idx = 0;
    end else if (en) begin
      if (e_valid) begin
        exp_q.delete(0); due_q.delete(0); m_last = e_data;
      end
      if (m_clearing) begin
        m_mem[m_clr_idx] = '0;
        if (m_clr_idx == 127) m_clearing = 1'b0;
        m_clr_idx++;
      end else if (chipselect && (read || write)) begin
        if (write) begin
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) m_mem[address][8*i +: 8] = writedata[8*i +: 8];
        end else begin
          exp_q.push_back(m_mem[address]);
          due_q.push_back(m_en_cnt + RL);
        end
      end
      m_en_cnt++;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_checks++; if (readdata !== '0) begin n_errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    n_checks++; if (readdatavalid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", readdatavalid); end
    n_checks++; if (waitrequest !== 1'b1) begin n_errors++; $display("FAIL reset_wait got=%b exp=1", waitrequest); end
    n_checks++; if (init_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", init_done); end
  endtask

  task automatic test_clear();
    int cnt = 0;
    int nval = 0;
    logic [AW-1:0] addrs [3] = '{7'd0, 7'd64, 7'd127};
    set_idle();
    for (int i = 0; i < 300; i++) begin
      step();
      if (o_wait !== 1'b1) break;
      cnt++;
    end
    n_checks++; if (cnt != 128) begin n_errors++; $display("FAIL clear_len got=%0d exp=128", cnt); end
    n_checks++; if (o_done !== 1'b1) begin n_errors++; $display("FAIL clear_done got=%b exp=1", o_done); end
    foreach (addrs[k]) begin
      set_cmd(1'b1, 1'b0, addrs[k], 4'h0, '0);
      for (int c = 0; c < 4; c++) begin
        step();
        if (c == 0) set_idle();
        n_checks++;
        if (o_valid !== e_valid) begin n_errors++; $display("FAIL clear_rd_valid a=%0d got=%b exp=%b", addrs[k], o_valid, e_valid); end
        if (o_valid === 1'b1) begin
          nval++;
          n_checks++; if (o_data !== 32'h0) begin n_errors++; $display("FAIL clear_rd_data a=%0d got=%h exp=00000000", addrs[k], o_data); end
        end
      end
    end
    n_checks++; if (nval != 3) begin n_errors++; $display("FAIL clear_rd_count got=%0d exp=3", nval); end
  endtask

  task automatic test_byte_lanes();
    int nval = 0;
    set_cmd(1'b0, 1'b1, 7'd5, 4'b1111, 32'hAABBCCDD); step();
    set_cmd(1'b0, 1'b1, 7'd5, 4'b0101, 32'h11223344); step();
    set_cmd(1'b1, 1'b0, 7'd5, 4'b0000, '0);          step();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_valid === 1'b1) begin
        nval++;
        n_checks++; if (o_data !== 32'hAA22CC44) begin n_errors++; $display("FAIL lanes_data got=%h exp=aa22cc44", o_data); end
      end
    end
    n_checks++; if (nval != 1) begin n_errors++; $display("FAIL lanes_count got=%0d exp=1", nval); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [3];
    int hits [$];
    int nd = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      set_cmd(1'b0, 1'b1, AW'(i + 1), 4'hF, d[i]); step();
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 3) set_cmd(1'b1, 1'b0, AW'(c + 1), 4'h0, '0);
      else       set_idle();
      step();
      if (o_valid === 1'b1) begin
        hits.push_back(c);
        n_checks++;
        if (nd >= 3 || o_data !== d[nd]) begin n_errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", nd, o_data, d[nd % 3]); end
        nd++;
      end
    end
    n_checks++;
    if (hits.size() != 3 || hits[0] != 2 || hits[1] != 3 || hits[2] != 4) begin
      n_errors++; $display("FAIL b2b_cycles got=%0d pulses (first=%0d) exp=3 at +2,+3,+4", hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] d = $urandom;
    int at = -1;
    set_cmd(1'b0, 1'b1, 7'd7, 4'hF, d); step();
    set_cmd(1'b1, 1'b0, 7'd7, 4'h0, '0); step();
    set_idle();
    reset_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (o_wait !== 1'b1)  begin n_errors++; $display("FAIL freeze_wait c=%0d got=%b exp=1", c, o_wait); end
      n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL freeze_valid c=%0d got=%b exp=0", c, o_valid); end
    end
    reset_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (o_valid === 1'b1 && at < 0) begin
        at = c;
        n_checks++; if (o_data !== d) begin n_errors++; $display("FAIL freeze_data got=%h exp=%h", o_data, d); end
      end
    end
    n_checks++; if (at != RL) begin n_errors++; $display("FAIL freeze_latency got=%0d exp=%0d", at, RL); end
  endtask

  task automatic test_collision();
    int nval = 0;
    set_cmd(1'b1, 1'b1, 7'd9, 4'hF, 32'h5); step();
    n_checks++; if (o_wait !== 1'b0) begin n_errors++; $display("FAIL coll_wait got=%b exp=0", o_wait); end
    set_cmd(1'b1, 1'b0, 7'd9, 4'h0, '0); step();
    set_idle();
    for (int c = 0; c < 4; c++) begin
      step();
      if (o_valid === 1'b1) begin
        nval++;
        n_checks++; if (o_data !== 32'h5) begin n_errors++; $display("FAIL coll_data got=%h exp=00000005", o_data); end
      end
    end
    n_checks++; if (nval != 1) begin n_errors++; $display("FAIL coll_count got=%0d exp=1", nval); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = 1'b0;
      clken      = ($urandom_range(0, 9) != 0);
      reset_req  = ($urandom_range(0, 9) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 2) == 0);
      address    = AW'($urandom_range(0, 15));
      byteenable = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      if (c >= 390) set_idle();
      step();
      n_checks++; if (o_wait !== e_wait)   begin n_errors++; $display("FAIL rand_wait c=%0d got=%b exp=%b", c, o_wait, e_wait); end
      n_checks++; if (o_done !== e_done)   begin n_errors++; $display("FAIL rand_done c=%0d got=%b exp=%b", c, o_done, e_done); end
      n_checks++; if (o_valid !== e_valid) begin n_errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      n_checks++; if (o_data !== e_data)   begin n_errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, o_data, e_data); end
    end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_drain got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    int cnt = 0;
    set_cmd(1'b1, 1'b0, 7'd3, 4'h0, '0); step();
    set_cmd(1'b1, 1'b0, 7'd4, 4'h0, '0); step();
    set_idle();
    reset = 1'b1; step(); reset = 1'b0;
    if (o_valid !== 1'b0) stale++;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_valid !== 1'b0) stale++;
      n_checks++; if (o_wait !== 1'b1) begin n_errors++; $display("FAIL rmid_wait c=%0d got=%b exp=1", c, o_wait); end
    end
    reset = 1'b1; step(); reset = 1'b0;
    if (o_valid !== 1'b0) stale++;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin
        n_checks++; if (o_data !== '0) begin n_errors++; $display("FAIL rmid_readdata got=%h exp=0", o_data); end
      end
      if (o_valid !== 1'b0) stale++;
      if (o_wait !== 1'b1) break;
      cnt++;
    end
    n_checks++; if (cnt != 128) begin n_errors++; $display("FAIL rmid_clear_len got=%0d exp=128", cnt); end
    n_checks++; if (stale != 0) begin n_errors++; $display("FAIL rmid_stale_valid got=%0d exp=0", stale); end
    n_checks++; if (o_done !== 1'b1) begin n_errors++; $display("FAIL rmid_done got=%b exp=1", o_done); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    set_idle();
    test_reset();
    test_clear();
    test_byte_lanes();
    test_back_to_back();
    test_freeze();
    test_collision();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
